// File: rtl/ecc_ff_mul.sv
// Bit-serial GF(2^m) polynomial-basis multiplier with built-in reduction.
// Computes q = a*b mod f(x), MSB-first, one bit of b per clock, so an
// operation takes exactly m RUN cycles.
//
// Handshake: start is sampled only while busy=0. An accepted start latches
// a and b, and busy rises on the following cycle. done pulses for exactly
// one cycle, and at that moment q carries the new product. q holds that
// value until the next done. The done cycle is already IDLE, so a start
// presented alongside done is accepted. That gives back-to-back throughput
// of m+1 cycles per operation.
module ecc_ff_mul #(
    parameter int            m    = 163,
    parameter logic [m-1:0]  POLY = m'('hC9)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [m-1:0] a,
    input  logic [m-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [m-1:0] q
);

    localparam int             CW       = $clog2(m);
    localparam logic [CW-1:0]  CNT_LAST = CW'(m - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    state_t         state_d;

    logic [m-1:0]   ra;
    logic [m-1:0]   rb;
    logic [m-1:0]   acc;
    logic [m-1:0]   q_r;
    logic [CW-1:0]  cnt;
    logic           done_r;

    logic           load;
    logic           step;
    logic           finish;
    logic [m-1:0]   shifted;
    logic [m-1:0]   acc_next;

    // Next-state logic: IDLE accepts start; RUN counts down and exits on cnt==0.
    always_comb begin
        state_d = state;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == '0) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One Horner step: acc*x reduced by f(x), then add ra if the current b bit is set.
    always_comb begin
        shifted  = {acc[m-2:0], 1'b0} ^ (acc[m-1] ? POLY : '0);
        acc_next = shifted ^ (rb[cnt] ? ra : '0);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath registers: operand latch, accumulator, bit counter, result and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra     <= '0;
            rb     <= '0;
            acc    <= '0;
            cnt    <= '0;
            q_r    <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= finish;
            if (load) begin
                ra  <= a;
                rb  <= b;
                acc <= '0;
                cnt <= CNT_LAST;
            end else if (step) begin
                acc <= acc_next;
                cnt <= cnt - 1'b1;
            end
            if (finish) begin
                q_r <= acc_next;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = done_r;
    assign q    = q_r;

endmodule

// File: tb/tb_ecc_ff_mul.sv
// Self-checking bench for ecc_ff_mul (GF(2^163), f = x^163+x^7+x^6+x^3+1).
// The reference product uses a full carry-less multiply followed by
// top-down reduction.
module tb_ecc_ff_mul;

    localparam int M = 163;
    localparam logic [M:0] F_FULL = {1'b1, 163'hC9};

    logic         clk;
    logic         rst;
    logic         start;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic         busy;
    logic         done;
    logic [M-1:0] q;

    int n_checks;
    int n_fails;
    int done_cnt;
    int cyc;

    logic [M-1:0] exp_q[$];

    ecc_ff_mul dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
        logic [2*M-2:0] p;
        p = '0;
        for (int i = 0; i < M; i++)
            if (y[i]) p = p ^ ((2*M-1)'(x) << i);
        for (int i = 2*M-2; i >= M; i--)
            if (p[i]) p = p ^ ((2*M-1)'(F_FULL) << (i - M));
        return p[M-1:0];
    endfunction

    function automatic logic [M-1:0] rand_val();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[M-1:0];
    endfunction

    // scoreboard: every done pops one expected product
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) check("done_unexpected", 1, 0);
            else check("q_product", q, exp_q.pop_front());
        end
    end

    // drive one start cycle; caller is at posedge+#1 with DUT idle
    task automatic issue(input logic [M-1:0] va, input logic [M-1:0] vb);
        a = va;
        b = vb;
        start = 1'b1;
        exp_q.push_back(gf_mul(va, vb));
        @(posedge clk); #1;
        start = 1'b0;
        a = rand_val();
        b = rand_val();
    endtask

    // wait for done with a cycle budget; reports cycles waited and busy cycles
    task automatic wait_done(output int n, output int n_busy);
        n = 0;
        n_busy = 0;
        while (!done && n < 1000) begin
            if (busy) n_busy++;
            @(posedge clk); #1;
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n, nb, d0, prev;
        logic [M-1:0] ones;
        n_checks = 0;
        n_fails = 0;
        done_cnt = 0;
        ones = '1;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_busy", M'(busy), 0);
        check("rst_done", M'(done), 0);
        check("rst_q", q, 0);
        rst = 1'b0;
        idle_cycles(2);

        // 1: a=1, b=1
        issue(M'(1), M'(1));
        wait_done(n, nb);
        check("t1_latency", M'(n), M'(163));
        check("t1_busy_cycles", M'(nb), M'(163));
        check("t1_q", q, M'(1));
        check("t1_busy_at_done", M'(busy), 0);
        idle_cycles(1);
        check("t1_done_one_cycle", M'(done), 0);
        idle_cycles(10);
        check("t1_q_hold", q, M'(1));

        // 2: reduction path x^162 * x
        issue(M'(1) << 162, M'(2));
        wait_done(n, nb);
        check("t2_q", q, M'('hC9));
        idle_cycles(2);

        // 3: zero operands, q holds between dones
        issue('0, ones);
        wait_done(n, nb);
        check("t3a_q", q, 0);
        idle_cycles(5);
        check("t3_q_hold", q, 0);
        issue(ones, '0);
        wait_done(n, nb);
        check("t3b_q", q, 0);
        idle_cycles(2);

        // 4: start while busy is ignored
        d0 = done_cnt;
        issue(rand_val() | M'(1), rand_val() | M'(1));
        idle_cycles(48);
        a = rand_val();
        b = rand_val();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n, nb);
        idle_cycles(200);
        check("t4_single_done", M'(done_cnt - d0), M'(1));
        check("t4_busy_after", M'(busy), 0);

        // 5: reset mid-operation aborts
        d0 = done_cnt;
        issue(rand_val(), rand_val());
        idle_cycles(79);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        check("t5_busy", M'(busy), 0);
        check("t5_done", M'(done), 0);
        check("t5_q", q, 0);
        idle_cycles(200);
        check("t5_no_done", M'(done_cnt - d0), 0);

        // 6: 200 random ops back-to-back, start in each done cycle
        prev = 0;
        issue(rand_val(), rand_val());
        for (int i = 0; i < 200; i++) begin
            wait_done(n, nb);
            if (i > 0) check("t6_spacing", M'(cyc - prev), M'(164));
            prev = cyc;
            if (i < 199) issue(rand_val(), rand_val());
        end
        idle_cycles(5);
        check("sb_empty", M'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
